// File: rtl/basket_controller.sv
// Basket storage for the sale terminal: an ordered list of (ProductID, Quantity)
// entries with merge-on-add, cancel-with-compaction, clear, and a display read port.
module basket_controller #(
  parameter int MAX_ITEMS = 8,
  parameter int QTY_MAX   = 15,
  parameter int ID_W      = 4,
  parameter int QTY_W     = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             Enable,
  input  logic [ID_W-1:0]  ProductID_in,
  input  logic [QTY_W-1:0] ProductQuantity,
  input  logic             Cancel,
  input  logic [3:0]       Cancel_Index,
  input  logic             Clear,
  input  logic [3:0]       Rd_Index,
  output logic [ID_W-1:0]  Rd_ProductID,
  output logic [QTY_W-1:0] Rd_Quantity,
  output logic [3:0]       BasketProductNum,
  output logic [7:0]       TotalItems,
  output logic             Busy,
  output logic             Full,
  output logic             Error,
  output logic [1:0]       dbg_state
);

  localparam int IW = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
  localparam logic [3:0]       MAX_CNT  = 4'(MAX_ITEMS);
  localparam logic [QTY_W:0]   SAT_WIDE = (QTY_W+1)'(QTY_MAX);
  localparam logic [QTY_W-1:0] SAT_QTY  = QTY_W'(QTY_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    WRITE   = 2'd2,
    COMPACT = 2'd3
  } state_t;

  // Handshake: Enable/Cancel/Clear are single-cycle pulses sampled on the rising
  // edge. Enable/Cancel are only accepted while Busy is low (IDLE); otherwise they
  // are dropped without Error. Clear is accepted in any state and wins over both.
  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q  [MAX_ITEMS];
  logic [ID_W-1:0]  id_d  [MAX_ITEMS];
  logic [QTY_W-1:0] qty_q [MAX_ITEMS];
  logic [QTY_W-1:0] qty_d [MAX_ITEMS];
  logic [3:0]       count_q, count_d;
  logic [7:0]       total_q, total_d;
  logic [3:0]       idx_q, idx_d;
  logic [ID_W-1:0]  lat_id_q, lat_id_d;
  logic [QTY_W-1:0] lat_qty_q, lat_qty_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;

  logic [IW-1:0]    cur;
  logic [3:0]       nxt_idx;
  logic [3:0]       cnt_m1;
  logic [QTY_W-1:0] old_qty;
  logic [QTY_W:0]   sum;
  logic [QTY_W-1:0] new_qty;
  logic             sat;

  always_comb begin
    cur     = idx_q[IW-1:0];
    nxt_idx = idx_q + 4'd1;
    cnt_m1  = count_q - 4'd1;
    old_qty = qty_q[cur];
    sum     = {1'b0, old_qty} + {1'b0, lat_qty_q};
    sat     = (sum > SAT_WIDE);
    new_qty = sat ? SAT_QTY : sum[QTY_W-1:0];

    state_d   = state_q;
    id_d      = id_q;
    qty_d     = qty_q;
    count_d   = count_q;
    total_d   = total_q;
    idx_d     = idx_q;
    lat_id_d  = lat_id_q;
    lat_qty_d = lat_qty_q;
    hit_d     = hit_q;
    err_d     = 1'b0;

    if (Clear) begin
      for (int k = 0; k < MAX_ITEMS; k++) begin
        id_d[k]  = '0;
        qty_d[k] = '0;
      end
      count_d = '0;
      total_d = '0;
      idx_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Cancel) begin
            if (Cancel_Index >= count_q) begin
              err_d = 1'b1;
            end else begin
              idx_d   = Cancel_Index;
              total_d = total_q - 8'(qty_q[Cancel_Index[IW-1:0]]);
              state_d = COMPACT;
            end
          end else if (Enable) begin
            if (ProductQuantity == '0) begin
              err_d = 1'b1;
            end else begin
              lat_id_d  = ProductID_in;
              lat_qty_d = ProductQuantity;
              idx_d     = '0;
              hit_d     = 1'b0;
              state_d   = (count_q == 4'd0) ? WRITE : SEARCH;
            end
          end
        end
        SEARCH: begin
          if (id_q[cur] == lat_id_q) begin
            hit_d   = 1'b1;
            state_d = WRITE;
          end else if (idx_q == cnt_m1) begin
            hit_d   = 1'b0;
            state_d = WRITE;
          end else begin
            idx_d = nxt_idx;
          end
        end
        WRITE: begin
          if (hit_q) begin
            qty_d[cur] = new_qty;
            total_d    = total_q + 8'(new_qty) - 8'(old_qty);
            err_d      = sat;
          end else if (count_q < MAX_CNT) begin
            id_d[count_q[IW-1:0]]  = lat_id_q;
            qty_d[count_q[IW-1:0]] = lat_qty_q;
            count_d = count_q + 4'd1;
            total_d = total_q + 8'(lat_qty_q);
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        COMPACT: begin
          // One shift per cycle; the vacated top slot is zeroed as count drops.
          if (idx_q < cnt_m1) begin
            id_d[cur]  = id_q[nxt_idx[IW-1:0]];
            qty_d[cur] = qty_q[nxt_idx[IW-1:0]];
            idx_d      = nxt_idx;
          end else begin
            id_d[cur]  = '0;
            qty_d[cur] = '0;
            count_d    = cnt_m1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      for (int k = 0; k < MAX_ITEMS; k++) begin
        id_q[k]  <= '0;
        qty_q[k] <= '0;
      end
      count_q   <= '0;
      total_q   <= '0;
      idx_q     <= '0;
      lat_id_q  <= '0;
      lat_qty_q <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      qty_q     <= qty_d;
      count_q   <= count_d;
      total_q   <= total_d;
      idx_q     <= idx_d;
      lat_id_q  <= lat_id_d;
      lat_qty_q <= lat_qty_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
    end
  end

  logic rd_valid;
  assign rd_valid         = (Rd_Index < count_q);
  assign Rd_ProductID     = rd_valid ? id_q[Rd_Index[IW-1:0]]  : '0;
  assign Rd_Quantity      = rd_valid ? qty_q[Rd_Index[IW-1:0]] : '0;
  assign BasketProductNum = count_q;
  assign TotalItems       = total_q;
  assign Busy             = (state_q != IDLE);
  assign Full             = (count_q == MAX_CNT);
  assign Error            = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_basket_controller.sv
// Bench for basket_controller: directed scenarios then random add/cancel/clear,
// checked against a list-level basket model.
module tb_basket_controller;

  logic       clk;
  logic       rst_n;
  logic       Enable;
  logic [3:0] ProductID_in;
  logic [3:0] ProductQuantity;
  logic       Cancel;
  logic [3:0] Cancel_Index;
  logic       Clear;
  logic [3:0] Rd_Index;
  logic [3:0] Rd_ProductID;
  logic [3:0] Rd_Quantity;
  logic [3:0] BasketProductNum;
  logic [7:0] TotalItems;
  logic       Busy;
  logic       Full;
  logic       Error;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  // Basket model: each entry is {id, qty}, in basket order.
  logic [7:0] exp_q[$];

  basket_controller dut (
    .CLOCK_50        (clk),
    .RESET_N         (rst_n),
    .Enable          (Enable),
    .ProductID_in    (ProductID_in),
    .ProductQuantity (ProductQuantity),
    .Cancel          (Cancel),
    .Cancel_Index    (Cancel_Index),
    .Clear           (Clear),
    .Rd_Index        (Rd_Index),
    .Rd_ProductID    (Rd_ProductID),
    .Rd_Quantity     (Rd_Quantity),
    .BasketProductNum(BasketProductNum),
    .TotalItems      (TotalItems),
    .Busy            (Busy),
    .Full            (Full),
    .Error           (Error),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int tot;
    logic [7:0] e;
    tot = 0;
    foreach (exp_q[k]) tot += int'(exp_q[k][3:0]);
    check({tag, ".count"}, 32'(BasketProductNum), exp_q.size());
    check({tag, ".total"}, 32'(TotalItems), tot);
    check({tag, ".full"},  32'(Full), (exp_q.size() == 8) ? 1 : 0);
    check({tag, ".busy"},  32'(Busy), 0);
    for (int r = 0; r < 16; r++) begin
      Rd_Index = 4'(r);
      #1;
      e = (r < exp_q.size()) ? exp_q[r] : 8'h00;
      check({tag, ".rd_id"},  32'(Rd_ProductID), 32'(e[7:4]));
      check({tag, ".rd_qty"}, 32'(Rd_Quantity),  32'(e[3:0]));
    end
  endtask

  // reference model
  task automatic model_add(input int id, input int q, output int eb, output int ee);
    int hit;
    int s;
    hit = -1;
    eb = 0;
    ee = 0;
    if (q == 0) begin
      ee = 1;
    end else begin
      foreach (exp_q[k]) if (hit < 0 && int'(exp_q[k][7:4]) == id) hit = k;
      if (hit >= 0) begin
        eb = hit + 2;
        s = int'(exp_q[hit][3:0]) + q;
        if (s > 15) begin
          s = 15;
          ee = 1;
        end
        exp_q[hit][3:0] = 4'(s);
      end else begin
        eb = exp_q.size() + 1;
        if (exp_q.size() == 8) ee = 1;
        else exp_q.push_back({4'(id), 4'(q)});
      end
    end
  endtask

  task automatic model_cancel(input int k, output int eb, output int ee);
    if (k >= exp_q.size()) begin
      eb = 0;
      ee = 1;
    end else begin
      eb = exp_q.size() - k;
      ee = 0;
      exp_q.delete(k);
    end
  endtask

  // driver: one-cycle pulse, then observe Busy/Error over a fixed window
  task automatic run_op(input string tag, input logic en, input logic cn, input logic cl,
                        input int id, input int q, input int ci, input bit inject,
                        input int exp_busy, input int exp_err);
    int busy_n;
    int err_n;
    logic first_busy;
    @(negedge clk);
    Enable = en;
    Cancel = cn;
    Clear = cl;
    ProductID_in = 4'(id);
    ProductQuantity = 4'(q);
    Cancel_Index = 4'(ci);
    @(negedge clk);
    Enable = 1'b0;
    Cancel = 1'b0;
    Clear = 1'b0;
    first_busy = Busy;
    busy_n = 0;
    err_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (Busy === 1'b1) busy_n++;
      if (Error === 1'b1) err_n++;
      if (inject && c == 1) begin
        Enable = 1'b1;
        ProductID_in = 4'hE;
        ProductQuantity = 4'd3;
      end else begin
        Enable = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, ".busy_start"}, 32'(first_busy), (exp_busy > 0) ? 1 : 0);
    check({tag, ".busy_cycles"}, busy_n, exp_busy);
    check({tag, ".error_cycles"}, err_n, exp_err);
    check_state(tag);
  endtask

  task automatic do_add(input string tag, input int id, input int q);
    int eb, ee;
    model_add(id, q, eb, ee);
    run_op(tag, 1'b1, 1'b0, 1'b0, id, q, 0, 1'b0, eb, ee);
  endtask

  task automatic do_cancel(input string tag, input int k, input bit inject);
    int eb, ee;
    model_cancel(k, eb, ee);
    run_op(tag, 1'b0, 1'b1, 1'b0, 0, 0, k, inject, eb, ee);
  endtask

  task automatic do_clear(input string tag);
    exp_q.delete();
    run_op(tag, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    Enable = 1'b0;
    Cancel = 1'b0;
    Clear = 1'b0;
    ProductID_in = '0;
    ProductQuantity = '0;
    Cancel_Index = '0;
    Rd_Index = '0;
    repeat (3) @(negedge clk);
    check("reset.error", 32'(Error), 0);
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // first add into empty basket, then merge onto an existing ID
    do_add("add_first", 3, 2);
    do_add("add_miss", 5, 1);
    do_add("add_hit", 3, 4);

    // saturation
    do_clear("clr1");
    do_add("sat_a", 7, 12);
    do_add("sat_b", 7, 9);

    // fill, overflow, cancel from the middle
    do_clear("clr2");
    for (int k = 0; k < 8; k++) do_add("fill", k, k + 1);
    do_add("overflow", 9, 1);
    do_cancel("cancel_mid", 2, 1'b0);

    // out-of-range cancel, zero quantity, Enable dropped while busy
    do_clear("clr3");
    do_add("small_a", 1, 3);
    do_add("small_b", 2, 3);
    do_add("small_c", 4, 3);
    do_cancel("cancel_oor", 4, 1'b0);
    do_add("zero_qty", 6, 0);
    do_cancel("cancel_busy_en", 0, 1'b1);

    // Clear in the middle of compaction
    do_add("pre_cc", 8, 2);
    do_add("pre_cc2", 9, 5);
    @(negedge clk);
    Cancel = 1'b1;
    Cancel_Index = 4'd0;
    @(negedge clk);
    Cancel = 1'b0;
    check("clr_compact.busy_before", 32'(Busy), 1);
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0;
    exp_q.delete();
    check("clr_compact.error", 32'(Error), 0);
    check_state("clr_compact");

    // reset in the middle of a search
    do_add("pre_rs_a", 1, 1);
    do_add("pre_rs_b", 2, 1);
    do_add("pre_rs_c", 3, 1);
    @(negedge clk);
    Enable = 1'b1;
    ProductID_in = 4'd12;
    ProductQuantity = 4'd4;
    @(negedge clk);
    Enable = 1'b0;
    check("rst_search.busy_before", 32'(Busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_search.error", 32'(Error), 0);
    check_state("rst_search");
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65) do_add("rnd_add", $urandom_range(0, 9), $urandom_range(0, 15));
      else if (r < 93) do_cancel("rnd_cancel", $urandom_range(0, 9), 1'b0);
      else do_clear("rnd_clear");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
